// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants, arctangent table and FSM states for the folded CORDIC.
package cordic_pkg;
    localparam int WORD_LENGTH = 21;
    localparam int NUM_ITER    = 16;
    localparam int K_INIT      = 318375;
    localparam int ROM_DEPTH   = 20;
    localparam int ATAN_ROM [ROM_DEPTH] = '{
        411775, 243084, 128440, 65198, 32725, 16379, 8191, 4096, 2048, 1024,
        512, 256, 128, 64, 32, 16, 8, 4, 2, 1
    };
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/cordic_iter_ctrl_if.sv
// cordic_iter_ctrl_if: angle-in / cos-sin-out valid-ready handshake bundle.
interface cordic_iter_ctrl_if #(parameter int WORD_LENGTH = cordic_pkg::WORD_LENGTH);
    logic                          in_valid_i;
    logic                          in_ready_o;
    logic signed [WORD_LENGTH-1:0] angle_i;
    logic                          out_valid_o;
    logic                          out_ready_i;
    logic signed [WORD_LENGTH-1:0] cos_o;
    logic signed [WORD_LENGTH-1:0] sin_o;
    logic                          busy_o;
    modport slave  (input  in_valid_i, angle_i, out_ready_i,
                    output in_ready_o, out_valid_o, cos_o, sin_o, busy_o);
    modport master (output in_valid_i, angle_i, out_ready_i,
                    input  in_ready_o, out_valid_o, cos_o, sin_o, busy_o);
endinterface

// File: rtl/cordic.sv
// cordic: one combinational rotation-mode micro-rotation; direction from the sign of z.
module cordic #(
    parameter int WORD_LENGTH = 21
) (
    input  logic                          rst,
    input  logic signed [WORD_LENGTH-1:0] x_i,
    input  logic signed [WORD_LENGTH-1:0] y_i,
    input  logic signed [WORD_LENGTH-1:0] z_i,
    input  logic signed [WORD_LENGTH-1:0] alpha_i,
    input  logic        [4:0]             iteration_i,
    output logic signed [WORD_LENGTH-1:0] next_x_o,
    output logic signed [WORD_LENGTH-1:0] next_y_o,
    output logic signed [WORD_LENGTH-1:0] next_z_o
);
    logic signed [WORD_LENGTH-1:0] xs, ys;
    logic                          neg;
    always_comb begin
        neg      = z_i[WORD_LENGTH-1];
        xs       = x_i >>> iteration_i;
        ys       = y_i >>> iteration_i;
        next_x_o = rst ? '0 : (neg ? x_i + ys : x_i - ys);
        next_y_o = rst ? '0 : (neg ? y_i - xs : y_i + xs);
        next_z_o = rst ? '0 : (neg ? z_i + alpha_i : z_i - alpha_i);
    end
endmodule

// File: rtl/cordic_iter_ctrl.sv
// cordic_iter_ctrl: folded CORDIC sequencer; owns x/y/z/iter state and the atan table,
// steps one shared stage per clock for NUM_ITER cycles, then holds cos/sin until taken.
module cordic_iter_ctrl
    import cordic_pkg::*;
#(
    parameter int WORD_LENGTH = cordic_pkg::WORD_LENGTH,
    parameter int NUM_ITER    = cordic_pkg::NUM_ITER
) (
    input logic               clk,
    input logic               rst,
    cordic_iter_ctrl_if.slave bus
);
    localparam logic [4:0] LAST = 5'(NUM_ITER - 1);

    state_t                        state_q, state_d;
    logic signed [WORD_LENGTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic signed [WORD_LENGTH-1:0] nx, ny, nz, alpha;
    logic        [4:0]             iter_q, iter_d;

    cordic #(.WORD_LENGTH(WORD_LENGTH)) u_stage (
        .rst        (rst),
        .x_i        (x_q),
        .y_i        (y_q),
        .z_i        (z_q),
        .alpha_i    (alpha),
        .iteration_i(iter_q),
        .next_x_o   (nx),
        .next_y_o   (ny),
        .next_z_o   (nz)
    );

    always_comb begin
        // iter rests at NUM_ITER in DONE, which may lie past the table end
        alpha   = iter_q < 5'(ROM_DEPTH) ? WORD_LENGTH'(ATAN_ROM[iter_q]) : '0;
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        iter_d  = iter_q;
        if (state_q == IDLE && bus.in_valid_i) begin
            state_d = RUN;
            x_d     = WORD_LENGTH'(K_INIT);
            y_d     = '0;
            z_d     = bus.angle_i;
            iter_d  = '0;
        end else if (state_q == RUN) begin
            x_d     = nx;
            y_d     = ny;
            z_d     = nz;
            iter_d  = iter_q + 5'd1;
            state_d = iter_q == LAST ? DONE : RUN;
        end else if (state_q == DONE && bus.out_ready_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            iter_q  <= iter_d;
        end
    end

    assign bus.in_ready_o  = state_q == IDLE;
    assign bus.out_valid_o = state_q == DONE;
    assign bus.busy_o      = state_q == RUN;
    assign bus.cos_o       = x_q;
    assign bus.sin_o       = y_q;
endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// tb_cordic_iter_ctrl: directed checks of reset, latency, accuracy, stall and streaming.
module tb_cordic_iter_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;

    cordic_iter_ctrl_if bus ();

    cordic_iter_ctrl dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic near(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs >= exp - 24 && obs <= exp + 24) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d+-24", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (bus.out_valid_o !== 1'b1 && n < 100) begin
            step();
            n++;
        end
    endtask

    function automatic int cosv();
        return int'($signed(bus.cos_o));
    endfunction

    function automatic int sinv();
        return int'($signed(bus.sin_o));
    endfunction

    task automatic op(input string tag, input int ang, input int ec, input int es);
        int n;
        chk({tag, "_ready"}, int'(bus.in_ready_o), 1);
        bus.angle_i    = 21'(ang);
        bus.in_valid_i = 1'b1;
        step();
        bus.in_valid_i = 1'b0;
        chk({tag, "_busy"}, int'(bus.busy_o), 1);
        wait_valid(n);
        chk({tag, "_latency"}, n, 16);
        near({tag, "_cos"}, cosv(), ec);
        near({tag, "_sin"}, sinv(), es);
        step();
        chk({tag, "_idle"}, int'(bus.in_ready_o), 1);
        chk({tag, "_novalid"}, int'(bus.out_valid_o), 0);
    endtask

    initial begin
        int n, cnt, hc, hs, ec, es;
        int tab [4] = '{549033, -411775, 52429, -629146};
        int t [4];
        real a;

        rst             = 1'b1;
        bus.in_valid_i  = 1'b0;
        bus.angle_i     = '0;
        bus.out_ready_i = 1'b1;
        step();
        step();
        chk("rst_ready", int'(bus.in_ready_o), 1);
        chk("rst_valid", int'(bus.out_valid_o), 0);
        chk("rst_busy", int'(bus.busy_o), 0);
        chk("rst_cos", cosv(), 0);
        chk("rst_sin", sinv(), 0);
        rst = 1'b0;

        // reset while iter==7
        bus.angle_i    = 21'(100000);
        bus.in_valid_i = 1'b1;
        step();
        bus.in_valid_i = 1'b0;
        repeat (7) step();
        chk("mid_busy", int'(bus.busy_o), 1);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("mid_rst_ready", int'(bus.in_ready_o), 1);
        chk("mid_rst_valid", int'(bus.out_valid_o), 0);
        chk("mid_rst_busy", int'(bus.busy_o), 0);
        chk("mid_rst_cos", cosv(), 0);
        chk("mid_rst_sin", sinv(), 0);
        cnt = 0;
        repeat (20) begin
            step();
            if (bus.out_valid_o === 1'b1) cnt++;
        end
        chk("mid_rst_noresult", cnt, 0);

        op("zero", 0, 524288, 0);
        op("pi4", 411775, 370728, 370728);
        op("mpi6", -274517, 454046, -262144);

        // consumer stall with a new angle pending
        bus.out_ready_i = 1'b0;
        bus.angle_i     = 21'(411775);
        bus.in_valid_i  = 1'b1;
        step();
        bus.in_valid_i  = 1'b0;
        wait_valid(n);
        chk("stall_latency", n, 16);
        hc = cosv();
        hs = sinv();
        near("stall_cos", hc, 370728);
        near("stall_sin", hs, 370728);
        bus.angle_i    = 21'(-274517);
        bus.in_valid_i = 1'b1;
        repeat (10) begin
            step();
            chk("stall_valid", int'(bus.out_valid_o), 1);
            chk("stall_ready", int'(bus.in_ready_o), 0);
            chk("stall_cos_hold", cosv(), hc);
            chk("stall_sin_hold", sinv(), hs);
        end
        bus.out_ready_i = 1'b1;
        step();
        chk("handoff_ready", int'(bus.in_ready_o), 1);
        chk("handoff_valid", int'(bus.out_valid_o), 0);
        chk("handoff_busy", int'(bus.busy_o), 0);
        step();
        chk("late_accept_busy", int'(bus.busy_o), 1);
        chk("late_accept_ready", int'(bus.in_ready_o), 0);
        bus.in_valid_i = 1'b0;
        wait_valid(n);
        chk("late_latency", n, 16);
        near("late_cos", cosv(), 454046);
        near("late_sin", sinv(), -262144);
        step();

        // back-to-back stream, producer keeps in_valid high
        bus.angle_i    = 21'(tab[0]);
        bus.in_valid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("b2b_ready%0d", k), int'(bus.in_ready_o), 1);
            step();
            wait_valid(n);
            chk($sformatf("b2b_latency%0d", k), n, 16);
            t[k] = cyc;
            a  = real'(tab[k]) / 524288.0;
            ec = int'($cos(a) * 524288.0);
            es = int'($sin(a) * 524288.0);
            near($sformatf("b2b_cos%0d", k), cosv(), ec);
            near($sformatf("b2b_sin%0d", k), sinv(), es);
            if (k > 0) chk($sformatf("b2b_gap%0d", k), t[k] - t[k-1], 18);
            if (k < 3) bus.angle_i = 21'(tab[k+1]);
            else bus.in_valid_i = 1'b0;
            step();
        end
        chk("end_idle", int'(bus.in_ready_o), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cordic_iter_ctrl.md
Name: cordic_iter_ctrl

Overview:
Folded (iterative) CORDIC sequencer in rotation mode. It owns the x/y/z state registers, the iteration counter and the arctangent constant ROM. It drives a single `cordic` iteration stage once per clock for NUM_ITER cycles, then presents cos/sin of the input angle. Upstream and downstream each use a valid/ready handshake. The block sits between the angle producer and the cos consumer in the function-evaluation datapath.

Parameters:
- WORD_LENGTH, 21: width of x/y/z/angle/results. Signed Q2.19 (sign, 1 integer bit, 19 fractional bits).
- NUM_ITER, 16: micro-rotations per operation. Legal range 1..20; must not exceed WORD_LENGTH-1.

Ports:
- clk, input, 1: the single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid_i, input, 1: angle_i is valid.
- in_ready_o, output, 1: block can accept an angle; high only in IDLE.
- angle_i, input, WORD_LENGTH: signed Q2.19 angle in radians; |angle| ≤ π/2 (823550).
- out_valid_o, output, 1: cos_o/sin_o are valid; high only in DONE.
- out_ready_i, input, 1: consumer accepts the result.
- cos_o, output, WORD_LENGTH: signed Q2.19 cosine (x register).
- sin_o, output, WORD_LENGTH: signed Q2.19 sine (y register).
- busy_o, output, 1: high in RUN.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE; x/y/z/iter=0; in_ready_o=1; out_valid_o=0; busy_o=0; cos_o=sin_o=0.
  - rst is also routed to the iteration stage's rst input.
  - Reset mid-RUN or in DONE discards the operation; no out_valid_o pulse follows.
- States:
  - IDLE: on in_valid_i&in_ready_o → x=K_INIT (318375, 0.6072529), y=0, z=angle_i, iter=0, go to RUN.
  - RUN: each edge, x/y/z ← stage next_x_o/next_y_o/next_z_o. Stage inputs are alpha_i=ATAN_ROM[iter] and iteration_i=iter. Then iter ← iter+1.
  - RUN → DONE: on the edge where iter==NUM_ITER-1 completes.
  - DONE: hold x/y/z/iter. On out_valid_o&out_ready_i → IDLE.
- Latency: accept at edge E0; iteration i is registered at edge E(i+1). out_valid_o is high from edge E(NUM_ITER), i.e. 16 cycles with default parameters. Throughput is one result per NUM_ITER+2 cycles minimum: accept, NUM_ITER iterations, handoff.
- Handshakes:
  - in_valid_i while not IDLE is ignored; the producer holds angle_i and in_valid_i until in_ready_o.
  - out_valid_o stays high, and cos_o/sin_o stay stable, until out_ready_i. No timeout.
  - out_ready_i outside DONE has no effect.
  - A handoff in DONE and a new in_valid_i in the same cycle: the new angle is not accepted that cycle; it is accepted the next cycle (IDLE).
- Arithmetic: all arithmetic is done by the stage, in two's-complement WORD_LENGTH bits, wrapping with no saturation. Rotation direction comes from the sign of z.
  - Results stay within Q2.19 for |angle| ≤ π/2.
  - Angles outside ±π/2 produce unconverged results; no error flag is raised.
- Counter: iter is 5 bits, matching the stage's iteration_i width. It is never compared beyond NUM_ITER-1.
- ATAN_ROM: combinational, indexed by iter. Entry i = round(atan(2^-i)·2^19). First three entries: 411775, 243084, 128440.

Decomposition:
- Package cordic_pkg: WORD_LENGTH default, K_INIT constant, ATAN_ROM array (20 entries, Q2.19), state enum {IDLE, RUN, DONE}.
- Sub-module: one instance of the existing `cordic` iteration stage, unmodified. The ROM is a constant lookup in the controller, not a separate module.

Test Plan:
1. rst high for 2 cycles mid-RUN (iter=7) → next cycle state IDLE; in_ready_o=1, out_valid_o=0, cos_o=sin_o=0; no result emitted afterward.
2. angle_i=0, out_ready_i=1 → out_valid_o rises exactly 16 cycles after accept; cos_o=524288±24, sin_o=0±24.
3. angle_i=411775 (π/4) → cos_o=370728±24, sin_o=370728±24.
4. angle_i=-274517 (-π/6) → cos_o=454046±24, sin_o=-262144±24.
5. out_ready_i=0 for 10 cycles after out_valid_o; in_valid_i held high with a new angle → out_valid_o and outputs stable, in_ready_o=0, angle not accepted. Raise out_ready_i → IDLE next cycle, new angle accepted the following cycle.
6. Back-to-back stream of 4 angles with out_ready_i=1 → 4 results in order, each 18 cycles apart, matching a reference model within ±24 LSB.
